// File: rtl/sync_diag_pipe_if.sv
// Operand/flag/capture bundle for sync_diag_pipe.
// The master drives the pipeline inputs; the slave returns the captured diagonal word.
interface sync_diag_pipe_if #(
  parameter int DATA_W = 48,
  parameter int TAP_W  = 4,
  parameter int FLAG_W = 25
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [TAP_W-1:0]  tap_sel;
  logic              flush;
  logic [FLAG_W-1:0] flag_in;
  logic [DATA_W-1:0] diag_out;
  logic              diag_valid;
  logic              diag_fresh;
  logic [7:0]        miss_count;

  modport master (
    output in_valid, in_data, tap_sel, flush, flag_in,
    input  diag_out, diag_valid, diag_fresh, miss_count
  );

  modport slave (
    input  in_valid, in_data, tap_sel, flush, flag_in,
    output diag_out, diag_valid, diag_fresh, miss_count
  );
endinterface

// File: rtl/sync_diag_pipe.sv
// Delay-and-capture pipeline: a MAX_DEPTH-stage tagged shift register whose runtime-selected
// stage is latched into a held diagonal register when the late adder flag bit is set.
module sync_diag_pipe #(
  parameter int DATA_W    = 48,
  parameter int MAX_DEPTH = 15,
  parameter int TAP_W     = 4,
  parameter int FLAG_W    = 25,
  parameter int FLAG_BIT  = 24
) (
  input  logic           clock,
  input  logic           reset_n,
  sync_diag_pipe_if.slave bus
);
  localparam int TW = TAP_W + 1;

  logic [DATA_W-1:0] data_q [1:MAX_DEPTH];
  logic [DATA_W-1:0] data_d [1:MAX_DEPTH];
  logic [MAX_DEPTH:1] vld_q, vld_d;

  logic [DATA_W-1:0] diag_out_q, diag_out_d;
  logic              diag_valid_q, diag_valid_d;
  logic              diag_fresh_q, diag_fresh_d;
  logic [7:0]        miss_q, miss_d;

  logic [TW-1:0]     tap;
  logic [DATA_W-1:0] tap_data;
  logic              tap_vld;
  logic              req;
  logic              hit;

  function automatic logic [TW-1:0] clamp_tap(input logic [TAP_W-1:0] sel);
    logic [TW-1:0] t;
    t = {1'b0, sel} + TW'(1);
    if (t > TW'(MAX_DEPTH)) t = TW'(MAX_DEPTH);
    return t;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Stage boundary: shift pipeline, data always moves, tags cleared by flush
  always_comb begin
    data_d[1] = bus.in_data;
    for (int k = 2; k <= MAX_DEPTH; k++) data_d[k] = data_q[k-1];
    vld_d = bus.flush ? '0 : {vld_q[MAX_DEPTH-1:1], bus.in_valid};
  end

  always_comb begin
    tap      = clamp_tap(bus.tap_sel);
    tap_data = '0;
    tap_vld  = 1'b0;
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      if (tap == TW'(k)) begin
        tap_data = data_q[k];
        tap_vld  = vld_q[k];
      end
    end
  end

  // Stage boundary: capture register, flush suppresses both capture and miss
  always_comb begin
    req          = bus.flag_in[FLAG_BIT] & ~bus.flush;
    hit          = req & tap_vld;
    diag_out_d   = hit ? tap_data : diag_out_q;
    diag_fresh_d = hit;
    diag_valid_d = bus.flush ? 1'b0 : (hit | diag_valid_q);
    miss_d       = (req & ~tap_vld) ? sat_inc(miss_q) : miss_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= MAX_DEPTH; k++) data_q[k] <= '0;
      vld_q        <= '0;
      diag_out_q   <= '0;
      diag_valid_q <= 1'b0;
      diag_fresh_q <= 1'b0;
      miss_q       <= '0;
    end else begin
      for (int k = 1; k <= MAX_DEPTH; k++) data_q[k] <= data_d[k];
      vld_q        <= vld_d;
      diag_out_q   <= diag_out_d;
      diag_valid_q <= diag_valid_d;
      diag_fresh_q <= diag_fresh_d;
      miss_q       <= miss_d;
    end
  end

  assign bus.diag_out   = diag_out_q;
  assign bus.diag_valid = diag_valid_q;
  assign bus.diag_fresh = diag_fresh_q;
  assign bus.miss_count = miss_q;
endmodule

// File: tb/tb_sync_diag_pipe.sv
// Bench for sync_diag_pipe: directed scenarios plus a randomized run against a history-queue model.
module tb_sync_diag_pipe;
  localparam int DATA_W    = 48;
  localparam int MAX_DEPTH = 15;
  localparam int TAP_W     = 4;
  localparam int FLAG_W    = 25;
  localparam int FLAG_BIT  = 24;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sync_diag_pipe_if #(.DATA_W(DATA_W), .TAP_W(TAP_W), .FLAG_W(FLAG_W)) bus ();

  sync_diag_pipe #(
    .DATA_W(DATA_W), .MAX_DEPTH(MAX_DEPTH), .TAP_W(TAP_W),
    .FLAG_W(FLAG_W), .FLAG_BIT(FLAG_BIT)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: hd/hv[i] is the word entered i+1 edges ago, i.e. stage i+1.
  logic [DATA_W-1:0] hd[$];
  logic              hv[$];
  logic [DATA_W-1:0] m_out;
  logic              m_valid;
  logic              m_fresh;
  int                m_miss;

  task automatic model_reset();
    hd.delete();
    hv.delete();
    m_out = '0; m_valid = 1'b0; m_fresh = 1'b0; m_miss = 0;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input int tap,
                       input logic fl, input logic fs);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.tap_sel  = TAP_W'(tap);
    bus.flush    = fs;
    bus.flag_in  = FLAG_W'($urandom);
    bus.flag_in[FLAG_BIT] = fl;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return DATA_W'({$urandom, $urandom});
  endfunction

  task automatic cycle();
    int t;
    logic sv, req, fs, iv;
    logic [DATA_W-1:0] sd, id;
    t = int'(bus.tap_sel) + 1;
    if (t > MAX_DEPTH) t = MAX_DEPTH;
    sv = 1'b0; sd = '0;
    if (hv.size() >= t) begin sv = hv[t-1]; sd = hd[t-1]; end
    fs = bus.flush; iv = bus.in_valid; id = bus.in_data;
    req = bus.flag_in[FLAG_BIT] & ~fs;
    @(posedge clock);
    m_fresh = 1'b0;
    if (req && sv) begin m_out = sd; m_valid = 1'b1; m_fresh = 1'b1; end
    else if (req && m_miss < 255) m_miss++;
    if (fs) begin
      m_valid = 1'b0;
      foreach (hv[i]) hv[i] = 1'b0;
      iv = 1'b0;
    end
    hd.push_front(id);
    hv.push_front(iv);
    if (hd.size() > MAX_DEPTH) begin void'(hd.pop_back()); void'(hv.pop_back()); end
    #1;
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    model_reset();
    #2 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 0, 1'b0, 1'b0);
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    n_chk++; if (bus.diag_out !== '0) begin n_fail++; $display("FAIL reset_out got %h want 0", bus.diag_out); end
    n_chk++; if (bus.diag_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.diag_valid); end
    n_chk++; if (bus.diag_fresh !== 1'b0) begin n_fail++; $display("FAIL reset_fresh got %b want 0", bus.diag_fresh); end
    n_chk++; if (bus.miss_count !== 8'd0) begin n_fail++; $display("FAIL reset_miss got %0d want 0", bus.miss_count); end
    #2 reset_n = 1'b1;
  endtask

  task automatic test_default_align();
    drive(1'b1, 48'h0000_1234_5678, 14, 1'b0, 1'b0);
    cycle();
    for (int i = 1; i <= 14; i++) begin
      drive(1'b0, rnd_data(), 14, 1'b0, 1'b0);
      cycle();
      n_chk++; if (bus.diag_valid !== 1'b0) begin n_fail++; $display("FAIL align_early edge %0d valid got %b want 0", i, bus.diag_valid); end
    end
    drive(1'b0, rnd_data(), 14, 1'b1, 1'b0);
    cycle();
    n_chk++; if ({bus.diag_out, bus.diag_valid, bus.diag_fresh} !== {48'h0000_1234_5678, 2'b11})
      begin n_fail++; $display("FAIL align_capture got out=%h v=%b f=%b want out=000012345678 v=1 f=1", bus.diag_out, bus.diag_valid, bus.diag_fresh); end
    drive(1'b0, rnd_data(), 14, 1'b0, 1'b0);
    cycle();
    n_chk++; if ({bus.diag_out, bus.diag_valid, bus.diag_fresh} !== {48'h0000_1234_5678, 2'b10})
      begin n_fail++; $display("FAIL align_hold got out=%h v=%b f=%b want out=000012345678 v=1 f=0", bus.diag_out, bus.diag_valid, bus.diag_fresh); end
  endtask

  task automatic test_runtime_tap();
    for (int n = 1; n <= 20; n++) begin
      drive(1'b1, DATA_W'(n), 3, (n >= 11), 1'b0);
      cycle();
      if (n >= 11) begin
        n_chk++; if ({bus.diag_out, bus.diag_fresh} !== {DATA_W'(n - 4), 1'b1})
          begin n_fail++; $display("FAIL tap3_stream edge %0d got out=%h f=%b want out=%h f=1", n, bus.diag_out, bus.diag_fresh, DATA_W'(n - 4)); end
      end
    end
    drive(1'b0, '0, 3, 1'b0, 1'b0);
    cycle();
  endtask

  task automatic test_clamp();
    logic [DATA_W-1:0] mk;
    mk = rnd_data();
    drive(1'b1, mk, 15, 1'b0, 1'b0);
    cycle();
    for (int i = 1; i <= 14; i++) begin
      drive(1'b0, rnd_data(), 15, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, rnd_data(), 15, 1'b1, 1'b0);
    cycle();
    n_chk++; if ({bus.diag_out, bus.diag_fresh} !== {mk, 1'b1})
      begin n_fail++; $display("FAIL clamp_tap15 got out=%h f=%b want out=%h f=1", bus.diag_out, bus.diag_fresh, mk); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), rnd_data(), int'($urandom_range(0, 15)),
            1'($urandom), ($urandom_range(0, 9) == 0));
      cycle();
      n_chk++;
      if ({bus.diag_out, bus.diag_valid, bus.diag_fresh, bus.miss_count} !== {m_out, m_valid, m_fresh, 8'(m_miss)})
        begin n_fail++; $display("FAIL random cyc %0d got out=%h v=%b f=%b m=%0d want out=%h v=%b f=%b m=%0d",
          i, bus.diag_out, bus.diag_valid, bus.diag_fresh, bus.miss_count, m_out, m_valid, m_fresh, m_miss); end
    end
  endtask

  task automatic test_miss_saturation();
    int want;
    pulse_reset();
    for (int i = 1; i <= 300; i++) begin
      drive(1'b0, rnd_data(), int'($urandom_range(0, 15)), 1'b1, 1'b0);
      cycle();
      want = (i > 255) ? 255 : i;
      n_chk++;
      if ({bus.diag_out, bus.diag_valid, bus.miss_count} !== {DATA_W'(0), 1'b0, 8'(want)})
        begin n_fail++; $display("FAIL miss_sat cyc %0d got out=%h v=%b m=%0d want out=0 v=0 m=%0d",
          i, bus.diag_out, bus.diag_valid, bus.miss_count, want); end
    end
  endtask

  task automatic test_flush();
    pulse_reset();
    drive(1'b1, DATA_W'(8'hAB), 0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, rnd_data(), 0, 1'b1, 1'b0);
    cycle();
    n_chk++; if ({bus.diag_out, bus.diag_valid} !== {DATA_W'(8'hAB), 1'b1})
      begin n_fail++; $display("FAIL flush_precapture got out=%h v=%b want out=ab v=1", bus.diag_out, bus.diag_valid); end
    drive(1'b1, DATA_W'(8'hCD), 0, 1'b1, 1'b1);
    cycle();
    n_chk++; if ({bus.diag_out, bus.diag_valid, bus.diag_fresh, bus.miss_count} !== {DATA_W'(8'hAB), 2'b00, 8'd0})
      begin n_fail++; $display("FAIL flush_cycle got out=%h v=%b f=%b m=%0d want out=ab v=0 f=0 m=0",
        bus.diag_out, bus.diag_valid, bus.diag_fresh, bus.miss_count); end
    drive(1'b0, rnd_data(), 0, 1'b1, 1'b0);
    cycle();
    n_chk++; if ({bus.diag_out, bus.diag_valid, bus.miss_count} !== {DATA_W'(8'hAB), 1'b0, 8'd1})
      begin n_fail++; $display("FAIL flush_after_miss got out=%h v=%b m=%0d want out=ab v=0 m=1",
        bus.diag_out, bus.diag_valid, bus.miss_count); end
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] x;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, rnd_data(), 2, 1'b1, 1'b0);
      cycle();
    end
    #3 reset_n = 1'b0;
    #1;
    n_chk++; if ({bus.diag_out, bus.diag_valid, bus.diag_fresh, bus.miss_count} !== '0)
      begin n_fail++; $display("FAIL async_reset got out=%h v=%b f=%b m=%0d want all 0",
        bus.diag_out, bus.diag_valid, bus.diag_fresh, bus.miss_count); end
    model_reset();
    #1 reset_n = 1'b1;
    x = rnd_data();
    drive(1'b1, x, 2, 1'b1, 1'b0);
    cycle();
    n_chk++; if ({bus.diag_valid, bus.miss_count} !== {1'b0, 8'd1})
      begin n_fail++; $display("FAIL post_reset_miss got v=%b m=%0d want v=0 m=1", bus.diag_valid, bus.miss_count); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, rnd_data(), 2, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, rnd_data(), 2, 1'b1, 1'b0);
    cycle();
    n_chk++; if ({bus.diag_out, bus.diag_valid, bus.diag_fresh} !== {x, 2'b11})
      begin n_fail++; $display("FAIL post_reset_capture got out=%h v=%b f=%b want out=%h v=1 f=1",
        bus.diag_out, bus.diag_valid, bus.diag_fresh, x); end
  endtask

  initial begin
    test_reset();
    test_default_align();
    test_runtime_tap();
    test_clamp();
    test_random();
    test_miss_saturation();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_diag_pipe.md
Name: sync_diag_pipe

Overview:
- Parametrised delay-and-capture block that aligns a wide operand with a late-arriving arithmetic flag.
- Data enters a MAX_DEPTH-stage shift pipeline with per-stage valid tags.
- When the selected flag bit of the adder result is set, the stage chosen at runtime by tap_sel is captured into a held diagonal output register.
- Adds what the fixed 15-stage version lacks: runtime tap selection, valid tracking, flush, capture pulse, and a miss counter.

Parameters:
- DATA_W, 48, width of pipelined data word.
- MAX_DEPTH, 15, number of pipeline stages (>= 2).
- TAP_W, 4, width of tap_sel; must satisfy 2^TAP_W >= MAX_DEPTH.
- FLAG_W, 25, width of flag_in bus.
- FLAG_BIT, 24, index within flag_in that triggers capture (< FLAG_W).

Ports:
- clock, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_data is valid this cycle.
- in_data, input, DATA_W, word entering stage 1.
- tap_sel, input, TAP_W, selected delay minus one; effective tap = min(tap_sel+1, MAX_DEPTH).
- flush, input, 1, synchronous clear of all valid tags and diag_valid.
- flag_in, input, FLAG_W, adder result; bit FLAG_BIT requests capture.
- diag_out, output, DATA_W, captured word, held between captures.
- diag_valid, output, 1, diag_out holds a captured word (sticky).
- diag_fresh, output, 1, one-cycle pulse the cycle after a capture edge.
- miss_count, output, 8, saturating count of capture requests that hit an invalid stage.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All stage data and valid tags = 0.
  - diag_out = 0, diag_valid = 0, diag_fresh = 0, miss_count = 0.
- Release from reset: first active edge is the first rising clock edge with reset_n high.
- Shift, every edge, unconditional:
  - d[1] <= in_data, v[1] <= in_valid.
  - d[k] <= d[k-1], v[k] <= v[k-1] for k = 2..MAX_DEPTH.
  - Invalid words still shift; only tags gate capture.
- Tap select:
  - tap = tap_sel+1, clamped to MAX_DEPTH when tap_sel+1 > MAX_DEPTH.
  - Combinational mux on the current registered stages; a tap_sel change takes effect the same cycle.
- Capture condition, evaluated on registered state before the edge:
  - req = flag_in[FLAG_BIT] & ~flush.
  - req & v[tap]:
    - diag_out <= d[tap], diag_valid <= 1, diag_fresh <= 1.
    - miss_count unchanged.
  - req & ~v[tap]:
    - diag_out held, diag_fresh <= 0.
    - miss_count <= miss_count+1, saturating at 255.
  - No req: diag_out held, diag_fresh <= 0.
- Latency: a word presented with in_valid at edge E sits in stage k after edge E+k-1. With tap_sel = k-1 and the flag high in the following cycle, diag_out updates at edge E+k. Default MAX_DEPTH=15 with tap_sel=14 gives a 15-cycle alignment plus the capture register.
- Flush (synchronous, highest priority after reset):
  - All v[k] <= 0, including v[1], so in_valid in the flush cycle is discarded.
  - Stage data still shifts.
  - diag_valid <= 0, diag_fresh <= 0; diag_out keeps its value.
  - A flag in the same cycle is ignored: no capture, no miss.
- Back-to-back flags capture every cycle. diag_fresh stays high continuously while consecutive captures succeed.
- Reset mid-operation: all state clears immediately; in-flight words are lost. miss_count is not otherwise clearable.

Test Plan:
- Reset then default alignment: tap_sel=14. Drive in_valid=1, in_data=0x0000_1234_5678 at edge 0, then in_valid=0. Flag bit24 high only in the cycle after edge 14.
  -> At edge 15: diag_out=0x0000_1234_5678, diag_valid=1, diag_fresh=1 for one cycle.
- Runtime tap: stream in_data=n for n=1..20, all valid. tap_sel=3, flag high from cycle 10 onward.
  -> Each capture equals the word entered 4 edges earlier (first capture 0x7). diag_fresh stays high.
- Clamp: tap_sel=15 with MAX_DEPTH=15.
  -> Behaves identically to tap_sel=14.
- Miss and saturation: pipeline empty, flag held high for 300 cycles.
  -> miss_count reaches 255 and stays. diag_valid=0, diag_out=0.
- Flush: after a valid capture (diag_out=0xAB), assert flush together with flag and in_valid.
  -> diag_valid=0, diag_out=0xAB, miss_count unchanged. Next-cycle flag with the same tap -> miss (stage invalid).
- Async reset mid-stream: pull reset_n low between edges during streaming.
  -> All outputs 0 immediately. The first capture after release needs freshly entered valid data.
